ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, SHALL be the PC loaded on reset.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 io_mem_req_valid  output  1  SHALL flag a fetch request.
REQ-005 io_mem_req_addr  output  64  SHALL carry the fetch address, equal to the current PC.
REQ-006 io_mem_req_ready  input  1  SHALL be memory acceptance of the request.
REQ-007 io_mem_resp_valid  input  1  SHALL flag returned instruction data; memory has no backpressure.
REQ-008 io_mem_resp_data  input  32  SHALL carry the fetched instruction word.
REQ-009 io_redirect_valid  input  1  SHALL flag a PC redirect (jump/branch) from downstream.
REQ-010 io_redirect_target  input  64  SHALL carry the redirect PC.
REQ-011 io_out_valid  output  1  SHALL flag a valid instruction to the decode stage.
REQ-012 io_out_ready  input  1  SHALL be decode-stage acceptance.
REQ-013 io_out_inst  output  32  SHALL carry the buffered instruction.
REQ-014 io_out_pc  output  64  SHALL carry the PC of io_out_inst.

Function
REQ-015 State machine SHALL have states IDLE, REQ, WAIT, OUT; one fetch outstanding at most.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-017 REQ: io_mem_req_valid=1, addr=PC; req_valid and addr SHALL stay stable until io_mem_req_ready=1; on handshake go to WAIT.
REQ-018 WAIT: on io_mem_resp_valid=1, capture resp_data into inst buffer and PC into pc buffer, go to OUT; resp_valid outside WAIT SHALL be ignored.
REQ-019 OUT: io_out_valid=1; inst/pc SHALL stay stable until io_out_ready=1; on handshake PC<=PC+4 (64-bit wrap) and go to REQ.
REQ-020 Minimum fetch latency SHALL be: request accepted cycle N, response cycle N+1, io_out_valid cycle N+2.
REQ-021 io_out_valid SHALL NOT depend combinationally on io_out_ready; io_mem_req_valid SHALL NOT depend combinationally on io_mem_req_ready.
REQ-022 Redirect in IDLE or REQ without same-cycle handshake: PC<=target, state stays/goes REQ; next-cycle addr=target.
REQ-023 Redirect in REQ with same-cycle handshake, or in WAIT: PC<=target, drop flag set; the pending response SHALL be discarded (no io_out_valid), then state goes REQ.
REQ-024 Redirect and io_mem_resp_valid in the same WAIT cycle: response discarded, PC<=target, go REQ, drop flag clear.
REQ-025 Redirect in OUT: buffer invalidated (io_out_valid=0 next cycle), PC<=target, go REQ; if io_out_ready=1 same cycle, the out handshake completes but PC<=target, not PC+4.
REQ-026 Redirect SHALL always take priority over PC+4 increment.
REQ-027 Redirect during WAIT while drop flag already set: PC<=latest target; only one response discarded.
REQ-028 PC low two bits SHALL be driven as given; no alignment exception generated.

Reset
REQ-029 When reset=0 at a clock edge: state<=IDLE, PC<=RESET_PC, drop flag<=0, inst buffer<=0, pc buffer<=0.
REQ-030 During and one cycle after reset: io_mem_req_valid=0, io_out_valid=0, io_mem_req_addr=RESET_PC, io_out_inst=0, io_out_pc=0.
REQ-031 Reset asserted mid-fetch SHALL abandon the transaction; a later stale io_mem_resp_valid SHALL be ignored (state IDLE/REQ).

Verification
REQ-032 Reset release, req_ready=1, resp 32'h00100093 next cycle, out_ready=1 -> out_valid with inst 32'h00100093, pc 64'h80000000; next req addr 64'h80000004.
REQ-033 req_ready=0 for 5 cycles -> req_valid held 1, addr 64'h80000000 constant; handshake on cycle 6.
REQ-034 out_ready=0 for 4 cycles in OUT -> out_valid, inst, pc stable; no new memory request issued.
REQ-035 Redirect target 64'h80000100 asserted in WAIT -> returning response discarded, no out_valid, next req addr 64'h80000100.
REQ-036 Redirect 64'h80000200 with out_ready=1 in OUT -> current instruction consumed once, next req addr 64'h80000200 (not pc+4).
REQ-037 Reset pulled low during WAIT, stale resp_valid one cycle after release -> ignored; first request addr 64'h80000000.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding memory fetch, a single-entry output buffer toward
// decode, and PC redirects that discard any fetch already in flight.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_mem_req_valid,
    output logic [63:0] io_mem_req_addr,
    input  logic        io_mem_req_ready,
    input  logic        io_mem_resp_valid,
    input  logic [31:0] io_mem_resp_data,
    input  logic        io_redirect_valid,
    input  logic [63:0] io_redirect_target,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [31:0] io_out_inst,
    output logic [63:0] io_out_pc
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] inst_q, inst_d;
    logic [63:0] out_pc_q, out_pc_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        drop_d   = drop_q;
        inst_d   = inst_q;
        out_pc_d = out_pc_q;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                if (io_redirect_valid) pc_d = io_redirect_target;
            end
            StReq: begin
                if (io_redirect_valid) pc_d = io_redirect_target;
                if (io_mem_req_ready) begin
                    state_d = StWait;
                    // The fetch just issued targets the old PC and must be thrown away.
                    if (io_redirect_valid) drop_d = 1'b1;
                end
            end
            StWait: begin
                if (io_redirect_valid) pc_d = io_redirect_target;
                if (io_mem_resp_valid) begin
                    if (io_redirect_valid || drop_q) begin
                        state_d = StReq;
                        drop_d  = 1'b0;
                    end else begin
                        inst_d   = io_mem_resp_data;
                        out_pc_d = pc_q;
                        state_d  = StOut;
                    end
                end else if (io_redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            StOut: begin
                if (io_redirect_valid) begin
                    pc_d    = io_redirect_target;
                    state_d = StReq;
                end else if (io_out_ready) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            inst_q   <= 32'd0;
            out_pc_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            inst_q   <= inst_d;
            out_pc_q <= out_pc_d;
        end
    end

    // Both valids come straight from state so neither loops back through its ready.
    assign io_mem_req_valid = (state_q == StReq);
    assign io_mem_req_addr  = pc_q;
    assign io_out_valid     = (state_q == StOut);
    assign io_out_inst      = inst_q;
    assign io_out_pc        = out_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a flag-based model checked every cycle, plus literal
// expectations at key points of each scenario.
module tb_ifu_fetch;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_mem_req_valid;
    logic [63:0] io_mem_req_addr;
    logic        io_mem_req_ready;
    logic        io_mem_resp_valid;
    logic [31:0] io_mem_resp_data;
    logic        io_redirect_valid;
    logic [63:0] io_redirect_target;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_out_inst;
    logic [63:0] io_out_pc;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_mem_req_valid   (io_mem_req_valid),
        .io_mem_req_addr    (io_mem_req_addr),
        .io_mem_req_ready   (io_mem_req_ready),
        .io_mem_resp_valid  (io_mem_resp_valid),
        .io_mem_resp_data   (io_mem_resp_data),
        .io_redirect_valid  (io_redirect_valid),
        .io_redirect_target (io_redirect_target),
        .io_out_valid       (io_out_valid),
        .io_out_ready       (io_out_ready),
        .io_out_inst        (io_out_inst),
        .io_out_pc          (io_out_pc)
    );

    always #5 clock = ~clock;

    // Model: "busy" = a fetch is in flight, "full" = the output buffer holds an instruction.
    logic        m_valid = 1'b0;
    logic        m_idle, m_busy, m_drop, m_full;
    logic [63:0] m_pc, m_bpc;
    logic [31:0] m_inst;

    always @(posedge clock) begin
        if (io_out_valid && io_out_ready) n_out <= n_out + 1;
        if (!reset) begin
            m_valid <= 1'b1;
            m_idle  <= 1'b1;
            m_busy  <= 1'b0;
            m_drop  <= 1'b0;
            m_full  <= 1'b0;
            m_pc    <= RESET_PC;
            m_inst  <= 32'd0;
            m_bpc   <= 64'd0;
        end else if (m_valid) begin
            if (m_idle) begin
                m_idle <= 1'b0;
                if (io_redirect_valid) m_pc <= io_redirect_target;
            end else if (m_full) begin
                if (io_redirect_valid || io_out_ready) m_full <= 1'b0;
                if (io_redirect_valid) m_pc <= io_redirect_target;
                else if (io_out_ready) m_pc <= m_pc + 64'd4;
            end else if (m_busy) begin
                if (io_redirect_valid) m_pc <= io_redirect_target;
                if (io_mem_resp_valid) begin
                    m_busy <= 1'b0;
                    m_drop <= 1'b0;
                    if (!io_redirect_valid && !m_drop) begin
                        m_full <= 1'b1;
                        m_inst <= io_mem_resp_data;
                        m_bpc  <= m_pc;
                    end
                end else if (io_redirect_valid) begin
                    m_drop <= 1'b1;
                end
            end else begin
                if (io_redirect_valid) m_pc <= io_redirect_target;
                if (io_mem_req_ready) begin
                    m_busy <= 1'b1;
                    if (io_redirect_valid) m_drop <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_valid) begin
            check("req_valid", 64'(io_mem_req_valid), 64'(!m_idle && !m_busy && !m_full));
            check("req_addr", io_mem_req_addr, m_pc);
            check("out_valid", 64'(io_out_valid), 64'(m_full));
            check("out_inst", 64'(io_out_inst), 64'(m_inst));
            check("out_pc", io_out_pc, m_bpc);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic quiet();
        io_mem_req_ready  = 1'b0;
        io_mem_resp_valid = 1'b0;
        io_mem_resp_data  = 32'd0;
        io_redirect_valid = 1'b0;
        io_out_ready      = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] t);
        io_redirect_valid  = 1'b1;
        io_redirect_target = t;
    endtask

    task automatic resp(input logic [31:0] d);
        io_mem_resp_valid = 1'b1;
        io_mem_resp_data  = d;
    endtask

    initial begin
        reset = 1'b0;
        io_redirect_target = 64'd0;
        quiet();
        tick(2);
        check("rst req_valid", 64'(io_mem_req_valid), 64'd0);
        check("rst out_valid", 64'(io_out_valid), 64'd0);
        check("rst addr", io_mem_req_addr, 64'h8000_0000);
        check("rst inst", 64'(io_out_inst), 64'd0);
        check("rst pc", io_out_pc, 64'd0);

        // Idle cycle after release, then a request held through 5 refused cycles.
        reset = 1'b1;
        check("idle req_valid", 64'(io_mem_req_valid), 64'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("hold req_valid", 64'(io_mem_req_valid), 64'd1);
            check("hold addr", io_mem_req_addr, 64'h8000_0000);
            tick();
        end
        io_mem_req_ready = 1'b1;
        tick();
        check("wait req_valid", 64'(io_mem_req_valid), 64'd0);
        quiet();
        resp(32'h0010_0093);
        tick();
        check("first out_valid", 64'(io_out_valid), 64'd1);
        check("first inst", 64'(io_out_inst), 64'h0010_0093);
        check("first pc", io_out_pc, 64'h8000_0000);

        // Decode stalls; a stray response outside WAIT must be ignored.
        quiet();
        resp(32'hdead_beef);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall out_valid", 64'(io_out_valid), 64'd1);
            check("stall inst", 64'(io_out_inst), 64'h0010_0093);
            check("stall req_valid", 64'(io_mem_req_valid), 64'd0);
        end
        quiet();
        io_out_ready = 1'b1;
        tick();
        quiet();
        check("next addr", io_mem_req_addr, 64'h8000_0004);
        check("next out_valid", 64'(io_out_valid), 64'd0);

        // Redirect while waiting: the returning response is dropped.
        io_mem_req_ready = 1'b1;
        tick();
        quiet();
        redirect(64'h8000_0100);
        tick();
        quiet();
        check("drop out_valid", 64'(io_out_valid), 64'd0);
        resp(32'h1111_1111);
        tick();
        quiet();
        check("drop2 out_valid", 64'(io_out_valid), 64'd0);
        check("redir addr", io_mem_req_addr, 64'h8000_0100);

        // Redirect in OUT together with out_ready.
        io_mem_req_ready = 1'b1;
        tick();
        quiet();
        resp(32'h0000_0013);
        tick();
        quiet();
        check("out pc 100", io_out_pc, 64'h8000_0100);
        redirect(64'h8000_0200);
        io_out_ready = 1'b1;
        tick();
        quiet();
        check("out redir valid", 64'(io_out_valid), 64'd0);
        check("out redir addr", io_mem_req_addr, 64'h8000_0200);
        check("consumed count", 64'(n_out), 64'd2);

        // Redirect coinciding with the response.
        io_mem_req_ready = 1'b1;
        tick();
        quiet();
        resp(32'h2222_2222);
        redirect(64'h8000_0300);
        tick();
        quiet();
        check("same-cycle out_valid", 64'(io_out_valid), 64'd0);
        check("same-cycle addr", io_mem_req_addr, 64'h8000_0300);
        io_mem_req_ready = 1'b1;
        tick();
        quiet();
        resp(32'h0000_00aa);
        tick();
        quiet();
        check("after drop inst", 64'(io_out_inst), 64'h0000_00aa);
        check("after drop pc", io_out_pc, 64'h8000_0300);
        io_out_ready = 1'b1;
        tick();
        quiet();

        // Redirect with handshake, a second redirect in WAIT, one response dropped.
        io_mem_req_ready = 1'b1;
        redirect(64'h8000_0400);
        tick();
        quiet();
        redirect(64'h8000_0500);
        tick();
        quiet();
        resp(32'h3333_3333);
        tick();
        quiet();
        check("double redir addr", io_mem_req_addr, 64'h8000_0500);
        io_mem_req_ready = 1'b1;
        tick();
        quiet();
        resp(32'h0000_0055);
        tick();
        quiet();
        check("one drop inst", 64'(io_out_inst), 64'h0000_0055);
        check("one drop pc", io_out_pc, 64'h8000_0500);
        io_out_ready = 1'b1;
        tick();
        quiet();

        // Unaligned redirect in REQ, then PC wrap past the top of the address space.
        redirect(64'h0000_0000_0000_1003);
        tick();
        quiet();
        check("unaligned addr", io_mem_req_addr, 64'h0000_0000_0000_1003);
        redirect(64'hffff_ffff_ffff_fffc);
        tick();
        quiet();
        io_mem_req_ready = 1'b1;
        tick();
        quiet();
        resp(32'h0000_0077);
        tick();
        quiet();
        io_out_ready = 1'b1;
        tick();
        quiet();
        check("wrap addr", io_mem_req_addr, 64'd0);

        // Reset during WAIT; stale responses after release are ignored.
        io_mem_req_ready = 1'b1;
        tick();
        quiet();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        resp(32'h0000_0099);
        tick();
        tick();
        quiet();
        check("post-rst req_valid", 64'(io_mem_req_valid), 64'd1);
        check("post-rst addr", io_mem_req_addr, 64'h8000_0000);
        check("post-rst out_valid", 64'(io_out_valid), 64'd0);
        check("post-rst inst", 64'(io_out_inst), 64'd0);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
